// File: rtl/nap_timer_sequencer_if.sv
// -----------------------------------------------------------------------------
// nap_timer_sequencer_if
//
// Request/response bundle between the nap-timer sequencer (initiator) and the
// BCD countdown-decrement unit (responder).
//
//   set_time  [23:0]  packed BCD {H10,H1,M10,M1,S10,S1} handed to the unit
//   start             one-cycle request strobe
//   get_time  [23:0]  packed BCD decremented result from the unit
//   complete          one-cycle response strobe
//   is_zero           unit reports that set_time was 00:00:00
//
// Modports:
//   master : the sequencer side (drives set_time/start)
//   slave  : the decrement-unit side (drives get_time/complete/is_zero)
// -----------------------------------------------------------------------------
interface nap_timer_sequencer_if;
  logic [23:0] set_time;
  logic        start;
  logic [23:0] get_time;
  logic        complete;
  logic        is_zero;

  modport master (
    output set_time,
    output start,
    input  get_time,
    input  complete,
    input  is_zero
  );

  modport slave (
    input  set_time,
    input  start,
    output get_time,
    output complete,
    output is_zero
  );
endinterface

// File: rtl/nap_timer_sequencer.sv
// -----------------------------------------------------------------------------
// nap_timer_sequencer
//
// Initiator side of the nap-timer countdown. Loads a user-entered HH:MM:SS,
// then once per prescaled second hands the current time to the BCD decrement
// unit, latches the decremented result for display and raises alarm when the
// countdown reaches 00:00:00. A decrement unit that never answers within
// CPL_TIMEOUT cycles parks the sequencer in a fault state until cancelled.
//
// Parameters:
//   TICK_DIV     clock cycles per one-second tick
//   CPL_TIMEOUT  cycles allowed in WAIT_CPL without complete before fault
//
// Build option:
//   NAP_PAUSE_EN  when defined, pause_i toggles a PAUSED state that freezes
//                 the prescaler and display. When undefined, pause_i is
//                 accepted but ignored and there is no PAUSED state.
//
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous active-low reset
//   go_i          level-sampled request to start counting down user_time_i
//   cancel_i      abort to IDLE, overrides every other input
//   pause_i       pause/resume pulse (NAP_PAUSE_EN only)
//   user_time_i   packed BCD {H10,H1,M10,M1,S10,S1}
//   dec_if        master side of the decrement-unit handshake
//   cur_time_o    packed BCD display value
//   running_o     countdown in progress (including paused)
//   alarm_o       countdown finished, held until go or cancel
//   fault_o       decrement unit timed out, held until cancel
// -----------------------------------------------------------------------------
module nap_timer_sequencer #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned CPL_TIMEOUT = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  go_i,
  input  logic                  cancel_i,
  input  logic                  pause_i,
  input  logic [23:0]           user_time_i,
  nap_timer_sequencer_if.master dec_if,
  output logic [23:0]           cur_time_o,
  output logic                  running_o,
  output logic                  alarm_o,
  output logic                  fault_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TW = $clog2(CPL_TIMEOUT) + 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(CPL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_TICK = 3'd2,
    ST_REQ       = 3'd3,
    ST_WAIT_CPL  = 3'd4,
    ST_DONE      = 3'd5,
    ST_ERR       = 3'd6
`ifdef NAP_PAUSE_EN
    , ST_PAUSED  = 3'd7
`endif
  } state_e;

  // A time is enterable when every digit is decimal and both tens-of-minutes
  // and tens-of-seconds stay within 0..5. Tens-of-hours may be 0..9.
  function automatic logic bcd_time_valid(input logic [23:0] t);
    return (t[23:20] <= 4'd9) && (t[19:16] <= 4'd9) &&
           (t[15:12] <= 4'd5) && (t[11:8]  <= 4'd9) &&
           (t[7:4]   <= 4'd5) && (t[3:0]   <= 4'd9);
  endfunction

  // running covers every state in which a countdown is still owned.
  function automatic logic state_is_running(input state_e s);
    logic r;
    case (s)
      ST_LOAD,
      ST_WAIT_TICK,
      ST_REQ,
      ST_WAIT_CPL: r = 1'b1;
`ifdef NAP_PAUSE_EN
      ST_PAUSED:   r = 1'b1;
`endif
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [TW-1:0] to_q, to_d;
  logic [23:0]   cur_q, cur_d;
  logic [23:0]   set_q, set_d;
  logic          start_q, start_d;
  logic          running_q, running_d;
  logic          alarm_q, alarm_d;
  logic          fault_q, fault_d;
  logic          user_valid_s;
  logic          pause_take_s;

`ifdef NAP_PAUSE_EN
  // A pause seen while a request is in flight is parked here until the
  // sequencer is back in WAIT_TICK.
  logic          pend_q, pend_d;

  assign pause_take_s = pause_i | pend_q;
`else
  logic          unused_pause_s;

  assign unused_pause_s = pause_i;
  assign pause_take_s   = 1'b0;
`endif

  assign user_valid_s = bcd_time_valid(user_time_i);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    to_d    = to_q;
    cur_d   = cur_q;
    set_d   = set_q;
    start_d = 1'b0;
`ifdef NAP_PAUSE_EN
    pend_d  = pend_q;
`endif

    if (cancel_i) begin
      // Display and last request are deliberately left untouched.
      state_d = ST_IDLE;
      pre_d   = '0;
`ifdef NAP_PAUSE_EN
      pend_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go_i && user_valid_s) begin
            if (user_time_i == 24'h00_0000) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            state_d = ST_IDLE;
          end
`ifdef NAP_PAUSE_EN
          pend_d = 1'b0;
`endif
        end

        ST_LOAD: begin
          cur_d   = user_time_i;
          pre_d   = '0;
          state_d = ST_WAIT_TICK;
        end

        ST_WAIT_TICK: begin
          if (pause_take_s) begin
            // Prescaler holds its count so the resumed second is not lost.
            state_d = ST_WAIT_TICK;
`ifdef NAP_PAUSE_EN
            state_d = ST_PAUSED;
            pend_d  = 1'b0;
`endif
          end else if (pre_q == PRE_LAST) begin
            pre_d   = '0;
            state_d = ST_REQ;
          end else begin
            pre_d   = pre_q + PW'(1);
          end
        end

        ST_REQ: begin
          set_d   = cur_q;
          start_d = 1'b1;
          to_d    = '0;
          state_d = ST_WAIT_CPL;
`ifdef NAP_PAUSE_EN
          pend_d  = pend_q | pause_i;
`endif
        end

        ST_WAIT_CPL: begin
          if (dec_if.complete) begin
            // Either zero indication ends the countdown; a zero result is
            // trusted even if the unit forgets to flag is_zero.
            if (dec_if.is_zero || (dec_if.get_time == 24'h00_0000)) begin
              cur_d   = 24'h00_0000;
              state_d = ST_DONE;
            end else begin
              cur_d   = dec_if.get_time;
              state_d = ST_WAIT_TICK;
            end
          end else if (to_q == TO_LAST) begin
            state_d = ST_ERR;
          end else begin
            to_d    = to_q + TW'(1);
          end
`ifdef NAP_PAUSE_EN
          pend_d = pend_q | pause_i;
`endif
        end

        ST_DONE: begin
          if (go_i) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end

        ST_ERR: begin
          // Only cancel (handled above) leaves the fault state.
          state_d = ST_ERR;
        end

`ifdef NAP_PAUSE_EN
        ST_PAUSED: begin
          if (pause_i) begin
            state_d = ST_WAIT_TICK;
          end else begin
            state_d = ST_PAUSED;
          end
        end
`endif

        default: begin
          state_d = ST_IDLE;
          pre_d   = '0;
        end
      endcase
    end

    running_d = state_is_running(state_d);
    fault_d   = (state_d == ST_ERR);
    // alarm rises one cycle after DONE is entered and drops on the same
    // edge that leaves DONE.
    alarm_d   = (state_q == ST_DONE) && (state_d == ST_DONE);
  end

  // State, counters, datapath and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      to_q      <= '0;
      cur_q     <= 24'h00_0000;
      set_q     <= 24'h00_0000;
      start_q   <= 1'b0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
      fault_q   <= 1'b0;
`ifdef NAP_PAUSE_EN
      pend_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      to_q      <= to_d;
      cur_q     <= cur_d;
      set_q     <= set_d;
      start_q   <= start_d;
      running_q <= running_d;
      alarm_q   <= alarm_d;
      fault_q   <= fault_d;
`ifdef NAP_PAUSE_EN
      pend_q    <= pend_d;
`endif
    end
  end

  assign dec_if.set_time = set_q;
  assign dec_if.start    = start_q;
  assign cur_time_o      = cur_q;
  assign running_o       = running_q;
  assign alarm_o         = alarm_q;
  assign fault_o         = fault_q;

endmodule
